// File: rtl/pipeline_loop_ring_pkg.sv
// Shared constants and helpers for the pipeline loop ring controller.
package pipeline_loop_pkg;

    localparam int unsigned PERF_W = 32;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        return (&v) ? v : v + PERF_W'(1);
    endfunction

endpackage

// File: rtl/pipeline_loop_ring_if.sv
// Upstream/downstream handshake and datapath control bundle of the loop ring.
interface pipeline_loop_ring_if #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 8,
    parameter int unsigned TAG_W = 2
);
    logic             i_valid;
    logic             i_ready;
    logic [CNT_W-1:0] i_iter;
    logic [TAG_W-1:0] i_tag;
    logic             o_valid;
    logic             o_ready;
    logic [TAG_W-1:0] o_tag;
    logic             d_cen;
    logic             d_sel_in;
    logic [DEPTH-1:0] d_vld;

    modport master (
        output i_valid, i_iter, i_tag, o_ready,
        input  i_ready, o_valid, o_tag, d_cen, d_sel_in, d_vld
    );

    modport slave (
        input  i_valid, i_iter, i_tag, o_ready,
        output i_ready, o_valid, o_tag, d_cen, d_sel_in, d_vld
    );
endinterface

// File: rtl/pipeline_loop_ring_perf.sv
// Activity counters for the loop ring: busy and stall saturate, done wraps.
module pipeline_loop_perf
    import pipeline_loop_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              busy,
    input  logic              stall,
    input  logic              done_hs,
    output logic [PERF_W-1:0] perf_busy,
    output logic [PERF_W-1:0] perf_done,
    output logic [PERF_W-1:0] perf_stall
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_busy  <= '0;
            perf_done  <= '0;
            perf_stall <= '0;
        end else begin
            if (busy)    perf_busy  <= sat_inc(perf_busy);
            if (done_hs) perf_done  <= perf_done + PERF_W'(1);
            if (stall)   perf_stall <= sat_inc(perf_stall);
        end
    end

endmodule

// File: rtl/pipeline_loop_ring.sv
// Flow control for a DEPTH-slot ring of tokens making per-token pass counts.
// Define PIPELINE_LOOP_RING_PERF_EN to add the perf_busy/perf_done/perf_stall counters.
module pipeline_loop_ring
    import pipeline_loop_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 8,
    parameter int unsigned TAG_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    pipeline_loop_ring_if.slave bus
`ifdef PIPELINE_LOOP_RING_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_busy,
    output logic [PERF_W-1:0] perf_done,
    output logic [PERF_W-1:0] perf_stall
`endif
);

    typedef struct packed {
        logic             vld;
        logic [CNT_W-1:0] rem;
        logic [TAG_W-1:0] tag;
    } slot_t;

    slot_t [DEPTH-1:0] slot_q, slot_d;
    slot_t             head;
    logic              done, adv, head_free, recirc;

    always_comb begin
        head      = slot_q[DEPTH-1];
        done      = head.vld && (head.rem == '0);
        recirc    = head.vld && (head.rem != '0);
        adv       = !(done && !bus.o_ready);
        head_free = !head.vld || (done && bus.o_ready);
    end

    // A recirculating head owns stage 0, so upstream insertion is implicitly blocked.
    always_comb begin
        slot_d = slot_q;
        if (adv) begin
            for (int k = int'(DEPTH) - 1; k > 0; k--) begin
                slot_d[k] = slot_q[k-1];
            end
            if (recirc) begin
                slot_d[0] = '{vld: 1'b1, rem: head.rem - CNT_W'(1), tag: head.tag};
            end else if (bus.i_valid && head_free) begin
                slot_d[0] = '{vld: 1'b1, rem: bus.i_iter, tag: bus.i_tag};
            end else begin
                slot_d[0] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    always_comb begin
        bus.i_ready  = head_free;
        bus.o_valid  = done;
        bus.o_tag    = head.tag;
        bus.d_cen    = adv;
        bus.d_sel_in = bus.i_valid && head_free;
        for (int k = 0; k < int'(DEPTH); k++) begin
            bus.d_vld[k] = slot_q[k].vld;
        end
    end

`ifdef PIPELINE_LOOP_RING_PERF_EN
    pipeline_loop_perf u_perf (
        .clk        (clk),
        .rst_n      (rst_n),
        .busy       (|bus.d_vld),
        .stall      (!adv),
        .done_hs    (done && bus.o_ready),
        .perf_busy  (perf_busy),
        .perf_done  (perf_done),
        .perf_stall (perf_stall)
    );
`endif

endmodule
